// File: rtl/tx8b10b_pkg.sv
// Shared 8b/10b definitions: code tables, K28.5 fill words, running-disparity type.
// Tables hold the RD- form of each sub-block; the mask bit says whether RD+ uses the complement.
package tx8b10b_pkg;

  typedef enum logic {
    RD_NEG = 1'b0,
    RD_POS = 1'b1
  } rd_t;

  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;

  // abcdei for D.0 .. D.31, RD- column
  localparam logic [5:0] ENC6_NEG [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  // set for D.0,1,2,4,7,8,15,16,23,24,27,29,30,31
  localparam logic [31:0] INV6_MASK = 32'hE981_8197;

  // fghj for D.x.0 .. D.x.P7, RD- column
  localparam logic [3:0] ENC4_NEG [0:7] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110
  };
  localparam logic [3:0] ENC4_A7_NEG = 4'b0111;
  // set for D.x.0, D.x.3, D.x.4, D.x.7
  localparam logic [7:0] INV4_MASK = 8'h99;

  function automatic rd_t rd_flip(input rd_t rd);
    return (rd == RD_NEG) ? RD_POS : RD_NEG;
  endfunction

  // Ones minus zeros over a 10-bit word.
  function automatic int word_disparity(input logic [9:0] w);
    return 2 * $countones(w) - 10;
  endfunction

endpackage

// File: rtl/enc_8b10b.sv
// Combinational 8b/10b data-character encoder (D.x.y only).
// RD is chained from the 5b/6b block into the 3b/4b block.
module enc_8b10b
  import tx8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  rd_t        rdIn,
  output logic [9:0] word,
  output rd_t        rdOut
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] code6;
  logic [3:0] code4;
  rd_t        rdMid;
  logic       alt7;

  assign x = data[4:0];
  assign y = data[7:5];

  always_comb begin
    code6 = ENC6_NEG[x];
    if (rdIn == RD_POS && INV6_MASK[x]) code6 = ~code6;
    rdMid = ($countones(code6) == 3) ? rdIn : rd_flip(rdIn);

    // A7 avoids a run of five identical bits across the sub-block boundary
    alt7 = (y == 3'd7) &&
           (((rdMid == RD_NEG) && (x inside {5'd17, 5'd18, 5'd20})) ||
            ((rdMid == RD_POS) && (x inside {5'd11, 5'd13, 5'd14})));

    code4 = alt7 ? ENC4_A7_NEG : ENC4_NEG[y];
    if (rdMid == RD_POS && (alt7 || INV4_MASK[y])) code4 = ~code4;
    rdOut = ($countones(code4) == 2) ? rdMid : rd_flip(rdMid);

    word = {code6, code4};
  end

endmodule

// File: rtl/tx_8b10b.sv
// Byte FIFO -> 8b/10b encoder -> 10-bit serializer, one bit per enabled clock, K28.5 fill when idle.
// Define TX8B10B_ASSERT_EN for simulation-only protocol and disparity checks.
module tx_8b10b
  import tx8b10b_pkg::*;
#(
  parameter logic [9:0] FILL_WORD_RD0  = K28_5_NEG,
  parameter logic [9:0] FILL_WORD_RD1  = K28_5_POS,
  parameter logic       FILL_WORD_FLIP = 1'b1,
  parameter int         LOG2_DEPTH     = 4
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] dataIn,
  input  logic       writeStrobe,
  output logic       dataPresent,
  output logic       halfFull,
  output logic       full,
  output logic       tx
);

  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] HALF_CNT  = (LOG2_DEPTH + 1)'(DEPTH / 2);

  logic [7:0]            mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wrPtr;
  logic [LOG2_DEPTH-1:0] rdPtr;
  logic [LOG2_DEPTH:0]   count;
  logic [LOG2_DEPTH:0]   countNext;
  logic                  push;
  logic                  pop;
  logic                  load;

  logic [3:0] bitCnt;
  logic [9:0] shiftReg;
  rd_t        rd;
  rd_t        rdNext;
  rd_t        encRd;
  logic [9:0] encWord;
  logic [9:0] loadWord;

  assign load = en && (bitCnt == 4'd0);
  assign push = writeStrobe && !full;
  assign pop  = load && (count != '0);

  always_comb begin
    countNext = count;
    if (push && !pop)      countNext = count + 1'b1;
    else if (pop && !push) countNext = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= dataIn;
  end

  // Flags are registered from the next count so they track count exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      dataPresent <= 1'b0;
      halfFull    <= 1'b0;
      full        <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count       <= countNext;
      dataPresent <= (countNext != '0);
      halfFull    <= (countNext >= HALF_CNT);
      full        <= (countNext == DEPTH_CNT);
    end
  end

  enc_8b10b uEnc (
    .data  (mem[rdPtr]),
    .rdIn  (rd),
    .word  (encWord),
    .rdOut (encRd)
  );

  always_comb begin
    loadWord = encWord;
    rdNext   = encRd;
    if (count == '0) begin
      loadWord = (rd == RD_NEG) ? FILL_WORD_RD0 : FILL_WORD_RD1;
      rdNext   = FILL_WORD_FLIP ? rd_flip(rd) : rd;
    end
  end

  // bit[9] goes out on the load edge; the shift register holds the remaining nine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCnt   <= 4'd0;
      shiftReg <= '0;
      tx       <= 1'b0;
      rd       <= RD_NEG;
    end else if (en) begin
      if (bitCnt == 4'd0) begin
        tx       <= loadWord[9];
        shiftReg <= {loadWord[8:0], 1'b0};
        rd       <= rdNext;
        bitCnt   <= 4'd1;
      end else begin
        tx       <= shiftReg[9];
        shiftReg <= {shiftReg[8:0], 1'b0};
        bitCnt   <= (bitCnt == 4'd9) ? 4'd0 : bitCnt + 4'd1;
      end
    end
  end

`ifdef TX8B10B_ASSERT_EN
  int wordSum;
  int loadDisp;

  assign loadDisp = word_disparity(loadWord);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordSum <= -1;
    end else begin
      if (writeStrobe && full)
        $error("tx_8b10b: writeStrobe while full, byte dropped");
      if (load) begin
        if (!(loadDisp inside {-2, 0, 2}))
          $error("tx_8b10b: word %b has disparity %0d", loadWord, loadDisp);
        if (!((wordSum + loadDisp) inside {-1, 1}))
          $error("tx_8b10b: running sum %0d at word boundary", wordSum + loadDisp);
        wordSum <= wordSum + loadDisp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tx_8b10b.sv
// Self-checking bench for tx_8b10b: a bit monitor deserializes tx and checks it against a table-driven 8b/10b model.
module tb_tx_8b10b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       writeStrobe = 1'b0;
  logic       dataPresent, halfFull, full, tx;
  logic       ws0 = 1'b0;
  logic       dp0, hf0, fu0, tx0;

  always #5 clk = ~clk;

  tx_8b10b dut (
    .clk(clk), .rst(rst), .en(en), .dataIn(dataIn), .writeStrobe(writeStrobe),
    .dataPresent(dataPresent), .halfFull(halfFull), .full(full), .tx(tx)
  );

  tx_8b10b #(.FILL_WORD_FLIP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .dataIn(dataIn), .writeStrobe(ws0),
    .dataPresent(dp0), .halfFull(hf0), .full(fu0), .tx(tx0)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [9:0] cap_q[$];

  localparam logic [9:0] KNEG = 10'b0011111010;
  localparam logic [9:0] KPOS = 10'b1100000101;
  localparam int DEPTH = 16;

  // Both RD columns written out in full, straight from the code tables.
  logic [5:0] t6n [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] t6p [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

  // rd: 0 = RD-, 1 = RD+
  function automatic logic [9:0] ref_enc(input logic [7:0] b, input logic rdIn);
    int x, y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic rd1;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    s6 = rdIn ? t6p[x] : t6n[x];
    rd1 = ($countones(s6) == 3) ? rdIn : ~rdIn;
    if (y == 7 && ((!rd1 && (x == 17 || x == 18 || x == 20)) ||
                   (rd1 && (x == 11 || x == 13 || x == 14))))
      s4 = rd1 ? 4'b1000 : 4'b0111;
    else
      s4 = rd1 ? t4p[y] : t4n[y];
    return {s6, s4};
  endfunction

  function automatic logic ref_rd_after(input logic [9:0] w, input logic rdIn);
    return ($countones(w) == 5) ? rdIn : ~rdIn;
  endfunction

  // Monitor: deserialize tx, check running sum, decode words against exp_q.
  logic       enPrev = 1'b0;
  logic       mRd = 1'b0;
  int         mSum = -1;
  int         mBits = 0;
  logic [9:0] mWord = '0;

  always @(posedge clk) enPrev <= en && !rst;

  always @(negedge clk) begin
    if (rst) begin
      mRd = 1'b0;
      mSum = -1;
      mBits = 0;
      exp_q.delete();
    end else if (enPrev) begin
      mSum += tx ? 1 : -1;
      mWord = {mWord[8:0], tx};
      mBits++;
      vectors++;
      if (mSum < -3 || mSum > 3) begin
        miscompares++;
        $display("FAIL run_sum: got %0d, required within -3..3", mSum);
      end
      if (mBits == 10) begin
        mBits = 0;
        vectors++;
        if (mSum != 1 && mSum != -1) begin
          miscompares++;
          $display("FAIL boundary_sum: got %0d, required +-1", mSum);
        end
        cap_q.push_back(mWord);
        if (mWord == (mRd ? KPOS : KNEG)) begin
          mRd = ~mRd;
        end else begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL word_unexpected: got %b, required fill %b", mWord, mRd ? KPOS : KNEG);
          end else begin
            logic [7:0] b;
            logic [9:0] e;
            b = exp_q.pop_front();
            e = ref_enc(b, mRd);
            if (mWord !== e) begin
              miscompares++;
              $display("FAIL word_data: byte %h got %b, required %b", b, mWord, e);
            end
            mRd = ref_rd_after(e, mRd);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    writeStrobe = 1'b0;
    repeat (3) @(negedge clk);
    cap_q.delete();
    rst = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    writeStrobe = 1'b1;
    dataIn = b;
    exp_q.push_back(b);
    @(negedge clk);
    writeStrobe = 1'b0;
  endtask

  task automatic wait_words(input int nWords, input int budget, input string name);
    int n = 0;
    while (cap_q.size() < nWords && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (cap_q.size() < nWords) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d words, required %0d", name, cap_q.size(), nWords);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    apply_reset();
    en = 1'b1;
    repeat (2) @(negedge clk);
    write_byte(8'h5a);
    write_byte(8'hc3);
    write_byte(8'h17);
    while (tx !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tx !== 1'b1 || dataPresent !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: tx=%b dataPresent=%b, required 1 1", tx, dataPresent);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b0 || dataPresent !== 1'b0 || halfFull !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: tx=%b dp=%b hf=%b full=%b, required 0 0 0 0",
               tx, dataPresent, halfFull, full);
    end
    repeat (2) @(negedge clk);
    cap_q.delete();
    rst = 1'b0;
    wait_words(1, 30, "post_reset");
    vectors++;
    if (cap_q.size() >= 1 && cap_q[0] !== KNEG) begin
      miscompares++;
      $display("FAIL post_reset_word: got %b, required %b", cap_q[0], KNEG);
    end
    en = 1'b0;
  endtask

  task automatic test_idle();
    logic [9:0] w0 [3];
    logic [9:0] pat;
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      w0[i / 10] = {w0[i / 10][8:0], tx0};
    end
    wait_words(4, 20, "idle");
    for (int k = 0; k < 4; k++) begin
      pat = (k % 2 == 0) ? KNEG : KPOS;
      vectors++;
      if (cap_q.size() > k && cap_q[k] !== pat) begin
        miscompares++;
        $display("FAIL idle_flip_word%0d: got %b, required %b", k, cap_q[k], pat);
      end
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (w0[k] !== KNEG) begin
        miscompares++;
        $display("FAIL idle_noflip_word%0d: got %b, required %b", k, w0[k], KNEG);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_d0_after_fill();
    logic [9:0] want [3];
    want[0] = KNEG;
    want[1] = 10'b0110001011;
    want[2] = KPOS;
    apply_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    write_byte(8'h00);
    wait_words(3, 60, "d0");
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (cap_q.size() > k && cap_q[k] !== want[k]) begin
        miscompares++;
        $display("FAIL d0_word%0d: got %b, required %b", k, cap_q[k], want[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_fifo_flags();
    int n = 0;
    int cnt = 0;
    apply_reset();
    en = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      writeStrobe = 1'b1;
      dataIn = 8'(i);
      if (cnt < DEPTH) begin
        exp_q.push_back(8'(i));
        cnt++;
      end
      @(negedge clk);
      vectors++;
      if (dataPresent !== 1'b1 || halfFull !== (cnt >= DEPTH / 2) || full !== (cnt == DEPTH)) begin
        miscompares++;
        $display("FAIL flags_push%0d: dp=%b hf=%b full=%b, required 1 %b %b",
                 i, dataPresent, halfFull, full, cnt >= DEPTH / 2, cnt == DEPTH);
      end
    end
    writeStrobe = 1'b0;
    en = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || cap_q.size() != DEPTH) begin
      miscompares++;
      $display("FAIL fifo_drain: got %0d left, %0d words, required 0 left, %0d words",
               exp_q.size(), cap_q.size(), DEPTH);
    end
    vectors++;
    if (dataPresent !== 1'b0 || halfFull !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL flags_empty: dp=%b hf=%b full=%b, required 0 0 0", dataPresent, halfFull, full);
    end
    en = 1'b0;
  endtask

  task automatic test_en_toggle();
    logic [7:0] b [4];
    logic [9:0] ew [4];
    logic       rdm = 1'b0;
    logic       want;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      write_byte(b[i]);
      ew[i] = ref_enc(b[i], rdm);
      rdm = ref_rd_after(ew[i], rdm);
    end
    for (int k = 0; k < 80; k++) begin
      en = (k % 2 == 0);
      @(negedge clk);
      want = ew[k / 20][9 - (k / 2) % 10];
      vectors++;
      if (tx !== want) begin
        miscompares++;
        $display("FAIL en_toggle_clk%0d: got %b, required %b", k, tx, want);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    int n = 0;
    int thr;
    apply_reset();
    while (sent < 2500 && cyc < 60000) begin
      thr = ((cyc / 500) % 2 == 0) ? 13 : 1;
      en = ($urandom_range(0, 7) != 0);
      if (!full && $urandom_range(0, 15) < thr) begin
        writeStrobe = 1'b1;
        dataIn = 8'($urandom);
        exp_q.push_back(dataIn);
        sent++;
      end else begin
        writeStrobe = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    writeStrobe = 1'b0;
    en = 1'b1;
    vectors++;
    if (sent != 2500) begin
      miscompares++;
      $display("FAIL random_writes: got %0d accepted, required 2500", sent);
    end
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: got %0d bytes undelivered, required 0", exp_q.size());
    end
    cap_q.delete();
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_d0_after_fill();
    test_fifo_flags();
    test_en_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
